// File: rtl/apb_uart_ctrl_pkg.sv
// Shared types for the APB UART requester arbiter: FSM states, default widths and
// the command bundle captured from a requester.
package apb_uart_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the caller owns the last_grant history bit.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant_onehot,
    output logic       grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
        grant_onehot = 2'b00;
        if (req != 2'b00) begin
            grant_onehot = grant_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/apb_uart_req_arbiter.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS sequencing with
// PREADY wait states and a timeout, and a one-cycle response pulse back to the owner.
module apb_uart_req_arbiter
    import apb_uart_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned     CntW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYC - 1);

    state_e              r_state;
    logic                r_last_grant;
    logic [CntW-1:0]     r_wait_cnt;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic [1:0]          w_grant_onehot;
    logic                w_grant_idx;
    logic                w_accept;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [1:0]          w_owner_onehot;

    rr_arb2 u_arb (
        .req          (req_valid),
        .last_grant   (r_last_grant),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx)
    );

    always_comb begin
        // Ready is masked during reset so no handshake can appear while PRESET is high.
        req_ready      = (r_state == StIdle && !PRESET) ? w_grant_onehot : 2'b00;
        w_accept       = (r_state == StIdle) && (req_valid != 2'b00);
        w_sel_write    = w_grant_idx ? req_write[1] : req_write[0];
        w_sel_addr     = w_grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        w_sel_wdata    = w_grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        w_owner_onehot = r_last_grant ? 2'b10 : 2'b01;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_wait_cnt   <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant_idx;
                        r_pwrite     <= w_sel_write;
                        r_paddr      <= w_sel_addr;
                        r_pwdata     <= w_sel_wdata;
                        r_psel       <= 1'b1;
                        r_penable    <= 1'b0;
                        r_wait_cnt   <= '0;
                        r_state      <= StSetup;
                    end
                end
                StSetup: begin
                    r_penable <= 1'b1;
                    r_state   <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_owner_onehot;
                        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                        r_rsp_err   <= PSLVERR;
                        r_state     <= StIdle;
                    end else if (r_wait_cnt == WaitLast) begin
                        // Slave never answered: abort with an error response.
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_owner_onehot;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= StIdle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CntW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign PSELx     = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: doc/apb_uart_req_arbiter.md
Name: apb_uart_req_arbiter

Overview:
APB master that lets two on-chip requesters share the single APB UART slave port. It arbitrates round-robin between requesters 0 and 1 and sequences each granted command as an APB transfer (SETUP then ACCESS, with PREADY wait states). It returns read data and error status to the requester that issued the command. It sits between the requesters (CPU-side port and DMA-side port) and apb_uart_top's APB slave interface.

Parameters:
ADDR_W, 4, APB address width (PADDR).
DATA_W, 8, APB data width (PWDATA/PRDATA).
TIMEOUT_CYC, 16, ACCESS cycles with PREADY=0 before the transfer is aborted; legal range 2..255.

Ports:
PCLK  in  1  clock, all logic on rising edge.
PRESET  in  1  reset; asynchronous, active-high.
req_valid  in  2  per-requester command valid; bit n = requester n.
req_ready  out  2  per-requester command accept; command transfers on an edge where valid&ready.
req_write  in  2  per-requester direction; 1 = write.
req_addr  in  2*ADDR_W  per-requester address; requester n uses bits [n*ADDR_W +: ADDR_W].
req_wdata  in  2*DATA_W  per-requester write data, packed the same way.
rsp_valid  out  2  one-cycle response pulse to requester n.
rsp_rdata  out  DATA_W  read data; valid while any rsp_valid bit is high.
rsp_err  out  1  error flag; valid while any rsp_valid bit is high.
PSELx  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  ADDR_W  APB address.
PWDATA  out  DATA_W  APB write data.
PRDATA  in  DATA_W  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (async, on PRESET=1): PSELx, PENABLE and PWRITE = 0; PADDR and PWDATA = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; state = IDLE; last_grant = 1, so requester 0 wins first.
- Reset mid-transfer: the in-flight transfer is dropped with no response. Outputs take reset values immediately.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - winner = the requester with valid that is not last_grant; otherwise the only valid one.
  - req_ready is combinational: high only for the winner, and only in IDLE. The other bit stays 0.
  - On that edge: capture write/addr/wdata, set last_grant = winner, go to SETUP.
  - Registered outputs from the next cycle: PSELx=1, PENABLE=0, PWRITE/PADDR/PWDATA = captured values.
- SETUP: lasts exactly one cycle. Next edge goes to ACCESS with PENABLE=1.
- ACCESS:
  - Sample PREADY each edge.
  - PREADY=1: go to IDLE. PSELx and PENABLE drop to 0. rsp_valid[grant] pulses for one cycle.
    - rsp_rdata = PRDATA for a read, 0 for a write.
    - rsp_err = PSLVERR.
  - PREADY=0: increment wait_cnt (width $clog2(TIMEOUT_CYC+1)).
    - When wait_cnt reaches TIMEOUT_CYC-1 with PREADY still 0: abort. Go to IDLE, drop PSELx/PENABLE, pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
  - wait_cnt clears on entering SETUP.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the end of ACCESS. After the transfer they hold their last values (no return to 0).
- Timing:
  - Minimum transfer, zero wait states: accept edge, SETUP cycle, ACCESS cycle, then rsp_valid in the following cycle.
  - Back-to-back commands: at least one IDLE cycle between transfers, in which rsp_valid and the next req_ready may coincide.
- Requester rules:
  - A requester holds valid and its command stable until ready.
  - It must accept rsp_valid unconditionally (no backpressure).
  - A requester may issue its next command before its response arrives; it is not accepted until IDLE.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- PSLVERR is ignored when PREADY=0.

Decomposition:
- Package apb_uart_ctrl_pkg: state enum (IDLE/SETUP/ACCESS), ADDR_W/DATA_W defaults, and a cmd_t struct {write, addr, wdata}.
- Sub-module rr_arb2: a 2-way round-robin arbiter.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_onehot[1:0], grant_idx.
  - Purely combinational. last_grant is held in the parent.

Test Plan:
- Requester 0 writes addr 0x1, data 0xA5 with PREADY tied 1 -> PSELx high 2 cycles, PENABLE high 1 cycle, PWDATA=0xA5, PADDR=0x1; rsp_valid=2'b01 with rsp_err=0, rsp_rdata=0x00.
- Requester 1 reads addr 0x1, slave returns PRDATA=0xA5 after 3 PREADY=0 cycles -> ACCESS lasts 4 cycles; rsp_valid=2'b10, rsp_rdata=0xA5, rsp_err=0.
- Both requesters valid continuously for 4 commands each -> grant order 0,1,0,1,...; each req_ready pulse is one-hot and only in IDLE.
- PREADY held 0, TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0, PSELx=0; next command proceeds normally.
- Read with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_rdata=PRDATA, rsp_valid to the owner only.
- Assert PRESET during ACCESS -> PSELx/PENABLE drop 0 asynchronously, no rsp_valid; after release, requester 0 wins first.
